xclk_transfer_scheduler: RTL and testbench

// - Shares one clk->mclk crossing channel (the existing per-bit register stage) between N_REQ fast-domain requesters.
// - Round-robin arbitration; the winner's word is captured and driven onto the channel.
// - The word is held stable for HOLD_CYCLES clk cycles, so the slow mclk side samples it cleanly.
// - A mandatory idle gap follows each transfer. Sits in the clk domain, directly in front of the crossing registers.

---
 rtl/xclk_transfer_scheduler_pkg.sv | 34 +++
 rtl/xclk_transfer_scheduler_rr_arbiter.sv | 35 +++
 rtl/xclk_transfer_scheduler.sv | 142 ++++++++++++++
 tb/tb_xclk_transfer_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xclk_transfer_scheduler_pkg.sv
// Shared definitions for the clk->mclk transfer scheduler: FSM state
// encodings and small constant-evaluation helpers used for sizing.
package xclk_transfer_scheduler_pkg;

  // FSM state encodings (kept as plain constants for legacy compatibility)
  localparam logic [1:0] XS_IDLE = 2'd0;
  localparam logic [1:0] XS_HOLD = 2'd1;
  localparam logic [1:0] XS_GAP  = 2'd2;

  typedef logic [1:0] xs_state_t;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        res = res + 1;
        v   = v >>> 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Larger of two integers
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xclk_transfer_scheduler_rr_arbiter.sv
// Purely combinational round-robin arbiter. Searches for the first asserted
// request starting one position above ptr and wrapping, so the requester that
// won last time becomes lowest priority.
module xclk_transfer_scheduler_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] pos_s;
  logic          hit_s;

  // Rotating priority search; only the first hit after ptr is recorded
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    pos_s = '0;
    hit_s = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos_s      = IW'((int'(ptr) + k) % N);
      hit_s      = ~any & req[pos_s];
      gnt[pos_s] = gnt[pos_s] | hit_s;
      idx        = hit_s ? pos_s : idx;
      any        = any | hit_s;
    end
  end

endmodule

// File: rtl/xclk_transfer_scheduler.sv
// Time-shares one clk->mclk crossing channel between N_REQ requesters.
// A round-robin winner's word is captured, held on xfer_data with xfer_valid
// high for HOLD_CYCLES clocks, then a GAP_CYCLES idle gap follows so the
// slow side always sees a low phase between words. All outputs registered.
module xclk_transfer_scheduler
  import xclk_transfer_scheduler_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         grant,
  output logic [DATA_W-1:0]        xfer_data,
  output logic                     xfer_valid,
  output logic                     xfer_tgl,
  output logic [$clog2(N_REQ)-1:0] xfer_id,
  output logic                     done,
  output logic                     busy
);

  localparam int IW    = $clog2(N_REQ);
  localparam int CNT_W = clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);

  // Reject parameter sets the timing scheme cannot honour
  if (N_REQ < 2) begin : g_bad_n_req
    $error("xclk_transfer_scheduler: N_REQ must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("xclk_transfer_scheduler: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("xclk_transfer_scheduler: GAP_CYCLES must be >= 1");
  end

  xs_state_t         state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IW-1:0]     ptr_r;
  logic [N_REQ-1:0]  grant_r;
  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic              tgl_r;
  logic [IW-1:0]     id_r;
  logic              done_r;
  logic              busy_r;

  logic [N_REQ-1:0]  arb_gnt_s;
  logic [IW-1:0]     arb_idx_s;
  logic              arb_any_s;
  logic [DATA_W-1:0] sel_data_s;

  xclk_transfer_scheduler_rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req (req),
    .ptr (ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s),
    .any (arb_any_s)
  );

  // One-hot mux of the winning requester's word
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data_s = arb_gnt_s[i] ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
    end
  end

  // Transfer FSM: arbitrate in IDLE, hold the word, then enforce the gap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= XS_IDLE;
      cnt_r   <= '0;
      ptr_r   <= IW'(N_REQ - 1);
      grant_r <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      tgl_r   <= 1'b0;
      id_r    <= '0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      grant_r <= '0;
      done_r  <= 1'b0;
      case (state_r)
        XS_IDLE: begin
          if (arb_any_s) begin
            grant_r <= arb_gnt_s;
            data_r  <= sel_data_s;
            id_r    <= arb_idx_s;
            ptr_r   <= arb_idx_s;
            valid_r <= 1'b1;
            tgl_r   <= ~tgl_r;
            busy_r  <= 1'b1;
            cnt_r   <= CNT_W'(HOLD_CYCLES - 1);
            state_r <= XS_HOLD;
          end else begin
            state_r <= XS_IDLE;
          end
        end
        XS_HOLD: begin
          if (cnt_r == '0) begin
            valid_r <= 1'b0;
            done_r  <= 1'b1;
            cnt_r   <= CNT_W'(GAP_CYCLES - 1);
            state_r <= XS_GAP;
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        XS_GAP: begin
          if (cnt_r == '0) begin
            busy_r  <= 1'b0;
            state_r <= XS_IDLE;
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
          state_r <= XS_IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_r;
  assign xfer_data  = data_r;
  assign xfer_valid = valid_r;
  assign xfer_tgl   = tgl_r;
  assign xfer_id    = id_r;
  assign done       = done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_xclk_transfer_scheduler.sv
// Bench for xclk_transfer_scheduler (N_REQ=4, DATA_W=8, HOLD=4, GAP=2).
// Expected words are queued when requests are driven and popped when a grant
// appears; cycle-level timing is checked against fixed expected patterns.
module tb_xclk_transfer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [7:0]  xfer_data;
  logic        xfer_valid;
  logic        xfer_tgl;
  logic [1:0]  xfer_id;
  logic        done;
  logic        busy;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
    logic [1:0] id;
    logic       t;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic exp_tgl;
  int   checks   = 0;
  int   failures = 0;
  bit   found;
  int   cyc;

  xclk_transfer_scheduler #(
    .N_REQ       (4),
    .DATA_W      (8),
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .xfer_data  (xfer_data),
    .xfer_valid (xfer_valid),
    .xfer_tgl   (xfer_tgl),
    .xfer_id    (xfer_id),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [7:0] d, input logic [1:0] id);
    exp_tgl = ~exp_tgl;
    exp_q.push_back('{g, d, id, exp_tgl});
  endtask

  task automatic wait_grant(input int max_c, output bit f, output int c);
    f = 1'b0;
    c = 0;
    while (!f && c < max_c) begin
      tick();
      c++;
      if (grant !== 4'b0000) f = 1'b1;
    end
  endtask

  task automatic wait_idle(input int max_c, output bit f);
    int c;
    f = 1'b0;
    c = 0;
    while (!f && c < max_c) begin
      tick();
      c++;
      if (busy === 1'b0 && xfer_valid === 1'b0) f = 1'b1;
    end
  endtask

  task automatic wait_done(input int max_c, output bit f, output int c);
    f = 1'b0;
    c = 0;
    while (!f && c < max_c) begin
      tick();
      c++;
      if (done === 1'b1) f = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req      = 4'hF;
    req_data = 32'h4433_2211;
    exp_q.delete();
    exp_tgl  = 1'b0;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000 || xfer_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got grant=%b valid=%b done=%b busy=%b want 0000/0/0/0",
               grant, xfer_valid, done, busy);
    end
    checks++;
    if (xfer_data !== 8'h00 || xfer_id !== 2'd0 || xfer_tgl !== 1'b0) begin
      failures++;
      $display("FAIL reset_data got data=%h id=%0d tgl=%b want 00/0/0", xfer_data, xfer_id, xfer_tgl);
    end
    rst_n = 1'b1;
    push_exp(4'b0001, 8'h11, 2'd0);
    wait_grant(4, found, cyc);
    checks++;
    if (!found || cyc != 1) begin
      failures++;
      $display("FAIL reset_first_latency got found=%0d cycles=%0d want 1/1", found, cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (grant !== e.g || xfer_data !== e.d || xfer_id !== e.id || xfer_tgl !== e.t || xfer_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_word got g=%b d=%h id=%0d t=%b v=%b want g=%b d=%h id=%0d t=%b v=1",
               grant, xfer_data, xfer_id, xfer_tgl, xfer_valid, e.g, e.d, e.id, e.t);
    end
    req = 4'b0000;
    wait_idle(12, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_idle got busy=%b want 0 within 12 cycles", busy);
    end
  endtask

  task automatic test_single_req();
    logic [7:1] ev_valid;
    logic [7:1] ev_done;
    logic [7:1] ev_busy;
    logic [7:1] ev_grant;
    ev_valid = 7'b1000111;
    ev_done  = 7'b0001000;
    ev_busy  = 7'b1011111;
    ev_grant = 7'b1000000;
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    push_exp(4'b0100, 8'hA5, 2'd2);
    wait_grant(4, found, cyc);
    checks++;
    if (!found || cyc != 1) begin
      failures++;
      $display("FAIL single_latency got found=%0d cycles=%0d want 1/1", found, cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (grant !== e.g || xfer_data !== e.d || xfer_id !== e.id || xfer_tgl !== e.t || xfer_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_word got g=%b d=%h id=%0d t=%b v=%b want g=%b d=%h id=%0d t=%b v=1",
               grant, xfer_data, xfer_id, xfer_tgl, xfer_valid, e.g, e.d, e.id, e.t);
    end
    push_exp(4'b0100, 8'hA5, 2'd2);
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (xfer_valid !== ev_valid[c] || done !== ev_done[c] || busy !== ev_busy[c] ||
          (grant !== 4'b0000) !== ev_grant[c] || xfer_data !== 8'hA5) begin
        failures++;
        $display("FAIL single_cycle%0d got v=%b done=%b busy=%b grant=%b data=%h want v=%b done=%b busy=%b grant_any=%b data=a5",
                 c, xfer_valid, done, busy, grant, xfer_data, ev_valid[c], ev_done[c], ev_busy[c], ev_grant[c]);
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (grant !== e.g || xfer_data !== e.d || xfer_id !== e.id || xfer_tgl !== e.t || xfer_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_resend got g=%b d=%h id=%0d t=%b v=%b want g=%b d=%h id=%0d t=%b v=1",
               grant, xfer_data, xfer_id, xfer_tgl, xfer_valid, e.g, e.d, e.id, e.t);
    end
    req = 4'b0000;
    wait_idle(12, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL single_idle got busy=%b want 0 within 12 cycles", busy);
    end
  endtask

  task automatic test_round_robin();
    req   = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    exp_tgl  = 1'b0;
    req_data = 32'h4433_2211;
    push_exp(4'b0001, 8'h11, 2'd0);
    push_exp(4'b0010, 8'h22, 2'd1);
    push_exp(4'b0100, 8'h33, 2'd2);
    push_exp(4'b1000, 8'h44, 2'd3);
    push_exp(4'b0001, 8'h11, 2'd0);
    req = 4'hF;
    for (int w = 0; w < 5; w++) begin
      wait_grant(10, found, cyc);
      checks++;
      if (!found || cyc != ((w == 0) ? 1 : 7)) begin
        failures++;
        $display("FAIL rr_spacing%0d got found=%0d cycles=%0d want 1/%0d", w, found, cyc, (w == 0) ? 1 : 7);
      end
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || xfer_data !== e.d || xfer_id !== e.id || xfer_tgl !== e.t || xfer_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_word%0d got g=%b d=%h id=%0d t=%b v=%b want g=%b d=%h id=%0d t=%b v=1",
                 w, grant, xfer_data, xfer_id, xfer_tgl, xfer_valid, e.g, e.d, e.id, e.t);
      end
    end
    req = 4'b0000;
    wait_idle(12, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rr_idle got busy=%b want 0 within 12 cycles", busy);
    end
  endtask

  task automatic test_data_change();
    req_data[7:0] = 8'h11;
    req = 4'b0001;
    push_exp(4'b0001, 8'h11, 2'd0);
    wait_grant(4, found, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!found || grant !== e.g || xfer_data !== e.d || xfer_id !== e.id || xfer_tgl !== e.t) begin
      failures++;
      $display("FAIL dchg_word got f=%0d g=%b d=%h id=%0d t=%b want g=%b d=%h id=%0d t=%b",
               found, grant, xfer_data, xfer_id, xfer_tgl, e.g, e.d, e.id, e.t);
    end
    req = 4'b0000;
    req_data[7:0] = 8'h22;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (xfer_valid !== 1'b1 || xfer_data !== 8'h11) begin
        failures++;
        $display("FAIL dchg_hold%0d got v=%b data=%h want v=1 data=11", c, xfer_valid, xfer_data);
      end
    end
    tick();
    checks++;
    if (xfer_valid !== 1'b0 || done !== 1'b1 || xfer_data !== 8'h11) begin
      failures++;
      $display("FAIL dchg_retire got v=%b done=%b data=%h want v=0 done=1 data=11", xfer_valid, done, xfer_data);
    end
    wait_idle(12, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL dchg_idle got busy=%b want 0 within 12 cycles", busy);
    end
  endtask

  task automatic test_reset_mid_hold();
    req = 4'b0010;
    push_exp(4'b0010, 8'h22, 2'd1);
    wait_grant(4, found, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!found || grant !== e.g || xfer_data !== e.d || xfer_id !== e.id || xfer_tgl !== e.t) begin
      failures++;
      $display("FAIL rmid_word got f=%0d g=%b d=%h id=%0d t=%b want g=%b d=%h id=%0d t=%b",
               found, grant, xfer_data, xfer_id, xfer_tgl, e.g, e.d, e.id, e.t);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (xfer_valid !== 1'b1) begin
      failures++;
      $display("FAIL rmid_second_valid got v=%b want 1", xfer_valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (xfer_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || xfer_tgl !== 1'b0 ||
        xfer_data !== 8'h00 || xfer_id !== 2'd0 || grant !== 4'b0000) begin
      failures++;
      $display("FAIL rmid_abort got v=%b done=%b busy=%b tgl=%b data=%h id=%0d grant=%b want all 0",
               xfer_valid, done, busy, xfer_tgl, xfer_data, xfer_id, grant);
    end
    rst_n   = 1'b1;
    exp_tgl = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || xfer_valid !== 1'b0) begin
        failures++;
        $display("FAIL rmid_quiet%0d got done=%b v=%b want 0/0", c, done, xfer_valid);
      end
    end
    req = 4'hF;
    push_exp(4'b0001, 8'h22, 2'd0);
    wait_grant(4, found, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!found || cyc != 1 || grant !== e.g || xfer_data !== e.d || xfer_id !== e.id || xfer_tgl !== e.t) begin
      failures++;
      $display("FAIL rmid_ptr_reset got f=%0d cyc=%0d g=%b d=%h id=%0d t=%b want cyc=1 g=%b d=%h id=%0d t=%b",
               found, cyc, grant, xfer_data, xfer_id, xfer_tgl, e.g, e.d, e.id, e.t);
    end
    req = 4'b0000;
    wait_idle(12, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rmid_idle got busy=%b want 0 within 12 cycles", busy);
    end
  endtask

  task automatic test_late_req();
    req = 4'b0100;
    push_exp(4'b0100, 8'h33, 2'd2);
    wait_grant(4, found, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!found || grant !== e.g || xfer_data !== e.d || xfer_id !== e.id || xfer_tgl !== e.t) begin
      failures++;
      $display("FAIL late_first got f=%0d g=%b d=%h id=%0d t=%b want g=%b d=%h id=%0d t=%b",
               found, grant, xfer_data, xfer_id, xfer_tgl, e.g, e.d, e.id, e.t);
    end
    req = 4'b0000;
    wait_done(8, found, cyc);
    checks++;
    if (!found || cyc != 4) begin
      failures++;
      $display("FAIL late_done got found=%0d cycles=%0d want 1/4", found, cyc);
    end
    req = 4'b0010;
    push_exp(4'b0010, 8'h22, 2'd1);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0000 || xfer_valid !== 1'b0) begin
        failures++;
        $display("FAIL late_gap_grant%0d got grant=%b v=%b want 0000/0", c, grant, xfer_valid);
      end
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (grant !== e.g || xfer_data !== e.d || xfer_id !== e.id || xfer_tgl !== e.t || xfer_valid !== 1'b1) begin
      failures++;
      $display("FAIL late_grant got g=%b d=%h id=%0d t=%b v=%b want g=%b d=%h id=%0d t=%b v=1",
               grant, xfer_data, xfer_id, xfer_tgl, xfer_valid, e.g, e.d, e.id, e.t);
    end
    req = 4'b0000;
    wait_idle(12, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL late_idle got busy=%b want 0 within 12 cycles", busy);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_data = 32'h0;
    exp_tgl  = 1'b0;
    test_reset();
    test_single_req();
    test_round_robin();
    test_data_change();
    test_reset_mid_hold();
    test_late_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
